keypad_entry_buffer: RTL

KEYPAD_ENTRY_BUFFER -- requirements
Module: keypad_entry_buffer

---
 rtl/keypad_entry_buffer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer
// Collects scanned keypad codes into a small digit buffer. Each key press
// produces exactly one action: a press is detected in SCAN, applied in LOAD,
// and the FSM then waits in RELEASE for a run of idle cycles before
// accepting another press. In decimal mode the buffer supports clear,
// backspace and enter. Enter commits the buffer to out_value with a
// valid/ready handshake.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   key_active : high while any debounced keypad row is asserted
//   key_code   : scanned key code, 4'hF = idle
//   digits     : entry buffer, newest digit in [3:0], empty slots 4'hF
//   count      : number of valid digits held (0..DIGITS)
//   overflow   : sticky, a digit arrived while the buffer was full
//   out_valid  : committed value available (decimal mode only)
//   out_value  : committed buffer contents
//   out_ready  : consumer accepts out_value when out_valid is also high
module keypad_entry_buffer #(
    parameter int DIGITS         = 4,
    parameter int MODE           = 0,
    parameter int SHIFT_ON_FULL  = 1,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_active,
    input  logic [3:0]                   key_code,
    output logic [4*DIGITS-1:0]          digits,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         overflow,
    output logic                         out_valid,
    output logic [4*DIGITS-1:0]          out_value,
    input  logic                         out_ready
);

    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);

    localparam logic [CW-1:0] FULL_C     = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE_C  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO_C = '0;
    localparam logic [RW-1:0] REL_LAST_C = RW'(RELEASE_CYCLES - 1);
    localparam logic [RW-1:0] REL_ONE_C  = RW'(1'b1);
    localparam logic [DW-1:0] EMPTY_C    = {DIGITS{4'hF}};

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE  = 3'd0,
        ACT_DIGIT = 3'd1,
        ACT_CLEAR = 3'd2,
        ACT_BACK  = 3'd3,
        ACT_ENTER = 3'd4
    } act_t;

    // Map a registered key code to the action it requests in the current mode.
    function automatic act_t decode_key(input logic [3:0] code);
        act_t act;
        if (MODE == 0) begin
            act = (code == 4'hF) ? ACT_NONE : ACT_DIGIT;
        end else begin
            case (code)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                4'h5, 4'h6, 4'h7, 4'h8, 4'h9: act = ACT_DIGIT;
                4'hA:                         act = ACT_CLEAR;
                4'hB:                         act = ACT_BACK;
                4'hE:                         act = ACT_ENTER;
                default:                      act = ACT_NONE;
            endcase
        end
        return act;
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      code_q, code_d;
    logic [RW-1:0]   rel_cnt_q, rel_cnt_d;
    logic [DW-1:0]   digits_q, digits_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_value_q, out_value_d;
    logic            apply_s;
    logic            busy_s;
    logic [DW-1:0]   shl_s;
    logic [DW-1:0]   shr_s;

    // Press detection, single-cycle apply and release-run counting.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        rel_cnt_d = rel_cnt_q;
        apply_s   = 1'b0;
        case (state_q)
            SCAN: begin
                if (key_active && (key_code != 4'hF)) begin
                    code_d  = key_code;
                    state_d = LOAD;
                end else begin
                    state_d = SCAN;
                end
            end
            LOAD: begin
                apply_s   = 1'b1;
                rel_cnt_d = '0;
                state_d   = RELEASE;
            end
            RELEASE: begin
                // Any activity restarts the idle run, so bounces or a held
                // key never produce a second action.
                if (key_active) begin
                    rel_cnt_d = '0;
                end else if (rel_cnt_q == REL_LAST_C) begin
                    rel_cnt_d = '0;
                    state_d   = SCAN;
                end else begin
                    rel_cnt_d = rel_cnt_q + REL_ONE_C;
                end
            end
            default: begin
                state_d   = SCAN;
                rel_cnt_d = '0;
            end
        endcase
    end

    // Buffer edits and commit handshake.
    always_comb begin
        digits_d    = digits_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        shl_s       = digits_q << 3'd4;
        shl_s[3:0]  = code_q;
        shr_s       = digits_q >> 3'd4;
        shr_s[DW-1 -: 4] = 4'hF;
        // A handshake accepted this cycle frees the output slot, so an
        // Enter applied in the same cycle may commit a new value.
        busy_s      = out_valid_q && !out_ready;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (apply_s) begin
            case (decode_key(code_q))
                ACT_DIGIT: begin
                    if (count_q == FULL_C) begin
                        overflow_d = 1'b1;
                        if (SHIFT_ON_FULL != 0) begin
                            digits_d = shl_s;
                        end else begin
                            digits_d = digits_q;
                        end
                    end else begin
                        digits_d = shl_s;
                        count_d  = count_q + CNT_ONE_C;
                    end
                end
                ACT_BACK: begin
                    if (count_q != CNT_ZERO_C) begin
                        digits_d = shr_s;
                        count_d  = count_q - CNT_ONE_C;
                    end else begin
                        digits_d = digits_q;
                    end
                end
                ACT_CLEAR: begin
                    digits_d   = EMPTY_C;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
                ACT_ENTER: begin
                    if (!busy_s && (count_q != CNT_ZERO_C)) begin
                        out_value_d = digits_q;
                        out_valid_d = 1'b1;
                        digits_d    = EMPTY_C;
                        count_d     = '0;
                        overflow_d  = 1'b0;
                    end else begin
                        digits_d = digits_q;
                    end
                end
                default: begin
                    digits_d = digits_q;
                end
            endcase
        end else begin
            digits_d = digits_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SCAN;
            code_q      <= 4'hF;
            rel_cnt_q   <= '0;
            digits_q    <= EMPTY_C;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            rel_cnt_q   <= rel_cnt_d;
            digits_q    <= digits_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
        end
    end

    assign digits    = digits_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign out_valid = (MODE == 1) ? out_valid_q : 1'b0;
    assign out_value = out_value_q;

endmodule
